// File: rtl/key_event_decoder_if.sv
// Key-event bus: debounced key level in, one-cycle event pulses and busy flag out.
interface key_event_decoder_if;
  logic key_down;
  logic single_click;
  logic double_click;
  logic long_press;
  logic auto_repeat;
  logic busy;

  modport master (
    output key_down,
    input  single_click,
    input  double_click,
    input  long_press,
    input  auto_repeat,
    input  busy
  );

  modport slave (
    input  key_down,
    output single_click,
    output double_click,
    output long_press,
    output auto_repeat,
    output busy
  );
endinterface

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into single/double click, long press and
// auto-repeat pulses using one shared cycle counter.
module key_event_decoder #(
  parameter int LONG_TIME   = 50_000_000,
  parameter int DOUBLE_GAP  = 12_500_000,
  parameter int REPEAT_TIME = 10_000_000
) (
  input logic              clk,
  input logic              rst,
  key_event_decoder_if.slave kbus
);

  localparam int MAX_TIME =
    (LONG_TIME > DOUBLE_GAP) ? ((LONG_TIME > REPEAT_TIME) ? LONG_TIME : REPEAT_TIME)
                             : ((DOUBLE_GAP > REPEAT_TIME) ? DOUBLE_GAP : REPEAT_TIME);
  localparam int CNT_W = $clog2(MAX_TIME) + 1;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOUBLE_GAP - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PRESS1   = 3'd1;
  localparam logic [2:0] GAP      = 3'd2;
  localparam logic [2:0] LONG     = 3'd3;
  localparam logic [2:0] WAIT_REL = 3'd4;

  logic [2:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             key_d;
  logic             rise, fall;
  logic             single_next, double_next, long_next, repeat_next;

  assign rise = kbus.key_down & ~key_d;
  assign fall = ~kbus.key_down & key_d;

  // A release always takes priority over a terminal count in the same cycle.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt + CNT_W'(1);
    single_next = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (rise) state_next = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_next = GAP;
        end else if (cnt == LONG_LAST) begin
          long_next  = 1'b1;
          state_next = LONG;
        end
      end
      GAP: begin
        if (rise) begin
          double_next = 1'b1;
          state_next  = WAIT_REL;
        end else if (cnt == GAP_LAST) begin
          single_next = 1'b1;
          state_next  = IDLE;
        end
      end
      LONG: begin
        if (fall) begin
          state_next = IDLE;
        end else if (cnt == REPEAT_LAST) begin
          repeat_next = 1'b1;
          cnt_next    = '0;
        end
      end
      WAIT_REL: begin
        cnt_next = '0;
        if (fall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (state_next != state) cnt_next = '0;
  end

  // key_d resets high so a key already held at reset release is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      key_d             <= 1'b1;
      kbus.single_click <= 1'b0;
      kbus.double_click <= 1'b0;
      kbus.long_press   <= 1'b0;
      kbus.auto_repeat  <= 1'b0;
      kbus.busy         <= 1'b0;
    end else begin
      state             <= state_next;
      cnt               <= cnt_next;
      key_d             <= kbus.key_down;
      kbus.single_click <= single_next;
      kbus.double_click <= double_next;
      kbus.long_press   <= long_next;
      kbus.auto_repeat  <= repeat_next;
      kbus.busy         <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Drives key level sequences into key_event_decoder and compares every cycle
// against expected events derived from press/release timing.
module tb_key_event_decoder;

  localparam int LONG_T = 20;
  localparam int GAP_T  = 10;
  localparam int REP_T  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bit lvl[$];
  bit exp_single[$], exp_double[$], exp_long[$], exp_rep[$], exp_busy[$];

  key_event_decoder_if kbus();

  key_event_decoder #(
    .LONG_TIME  (LONG_T),
    .DOUBLE_GAP (GAP_T),
    .REPEAT_TIME(REP_T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kbus(kbus)
  );

  always #10 clk = ~clk;

  logic [4:0] outs;
  assign outs = {kbus.single_click, kbus.double_click, kbus.long_press,
                 kbus.auto_repeat, kbus.busy};

  task automatic checkOutput(input string tag, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got s/d/l/r/b=%b expected %b", tag, got, want);
    end
  endtask

  task automatic add_seg(input bit level, input int len);
    for (int k = 0; k < len; k++) lvl.push_back(level);
  endtask

  function automatic int next_low(input int from);
    for (int j = from; j < lvl.size(); j++)
      if (!lvl[j]) return j;
    return lvl.size();
  endfunction

  // Index 0 never counts as a rise: the key is treated as pressed before it.
  function automatic int next_rise(input int from);
    for (int j = (from < 1) ? 1 : from; j < lvl.size(); j++)
      if (lvl[j] && !lvl[j-1]) return j;
    return lvl.size();
  endfunction

  task automatic build_expect();
    int n, i, t, rel, r, s, stop;
    n = lvl.size();
    exp_single.delete(); exp_double.delete(); exp_long.delete();
    exp_rep.delete();    exp_busy.delete();
    for (int k = 0; k < n; k++) begin
      exp_single.push_back(0); exp_double.push_back(0); exp_long.push_back(0);
      exp_rep.push_back(0);    exp_busy.push_back(0);
    end
    i = 1;
    while (i < n) begin
      t = next_rise(i);
      if (t >= n) break;
      rel = next_low(t);
      if (rel - t > LONG_T) begin
        exp_long[t + LONG_T] = 1;
        for (int k = t + LONG_T + REP_T; k < rel; k += REP_T) exp_rep[k] = 1;
        stop = rel;
      end else if (rel >= n) begin
        stop = n;
      end else begin
        r = next_rise(rel + 1);
        if (r < n && r - rel <= GAP_T) begin
          exp_double[r] = 1;
          stop = next_low(r);
        end else begin
          s = rel + GAP_T;
          if (s < n) exp_single[s] = 1;
          stop = (s < n) ? s : n;
        end
      end
      for (int k = t; k < stop; k++) exp_busy[k] = 1;
      i = stop + 1;
    end
  endtask

  task automatic applyStimulus(input string name);
    build_expect();
    @(negedge clk);
    kbus.key_down = lvl[0];
    rst = 1'b1;
    #1;
    checkOutput({name, " reset"}, outs, 5'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < lvl.size(); n++) begin
      kbus.key_down = lvl[n];
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s cyc %0d", name, n), outs,
                  {exp_single[n], exp_double[n], exp_long[n], exp_rep[n], exp_busy[n]});
      @(negedge clk);
    end
  endtask

  initial begin
    kbus.key_down = 1'b0;

    lvl.delete();
    add_seg(0, 5);  add_seg(1, 5);  add_seg(0, 15);
    add_seg(1, 5);  add_seg(0, 4);  add_seg(1, 5);  add_seg(0, 15);
    add_seg(1, 40); add_seg(0, 15);
    add_seg(1, 20); add_seg(0, 15);
    add_seg(1, 21); add_seg(0, 15);
    add_seg(1, 3);  add_seg(0, 10); add_seg(1, 3);  add_seg(0, 15);
    add_seg(1, 3);  add_seg(0, 11); add_seg(1, 3);  add_seg(0, 20);
    applyStimulus("directed");

    // Finish mid-press so the next reset lands while the decoder is busy.
    lvl.delete();
    add_seg(0, 5);  add_seg(1, 10);
    applyStimulus("midpress");

    lvl.delete();
    add_seg(1, 15); add_seg(0, 5);  add_seg(1, 4);  add_seg(0, 20);
    applyStimulus("held_reset");

    for (int seq = 0; seq < 4; seq++) begin
      lvl.delete();
      add_seg(0, 3);
      for (int g = 0; g < 25; g++) begin
        if ($urandom_range(0, 3) == 0) add_seg(1, $urandom_range(18, 45));
        else                           add_seg(1, $urandom_range(1, 22));
        add_seg(0, $urandom_range(1, 14));
      end
      add_seg(0, 20);
      applyStimulus($sformatf("random%0d", seq));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
